stopwatch_ctrl: RTL
===================

Name: stopwatch_ctrl

Overview:
Control FSM that sequences the 4-digit BCD stopwatch counter. It debounces three raw push-buttons (start/pause, clear, lap) and drives the counter's enable and clear. It also supplies the digit values for the display path, either passed live from the counter or frozen on a lap. It sits between the board key inputs and the counter, in the same 1 kHz clock domain.

Parameters:
DB_CYCLES, 20, consecutive stable samples required to accept a key level (20 ms at 1 kHz)
DB_W, 5, width of the debounce counter; must satisfy 2^DB_W > DB_CYCLES

Ports:
clk  in  1  system clock (1 kHz)
rst  in  1  synchronous reset, active-high
key_ps_n  in  1  raw start/pause button, active-low, asynchronous to clk
key_clr_n  in  1  raw clear button, active-low, asynchronous
key_lap_n  in  1  raw lap button, active-low, asynchronous
cnt_d4..cnt_d1  in  4 each  live BCD digits from the counter (d4 = most significant)
cnt_max  in  1  counter reads 9999
count_en  out  1  counter enable (level)
count_clr  out  1  one-cycle counter clear pulse
disp_d4..disp_d1  out  4 each  digits to the display path
state_out  out  2  current state encoding
lap_active  out  1  high while the display is frozen

Behaviour:
- One clock, clk. Reset is synchronous and active-high (rst). All outputs are registered.
- Reset values: state IDLE; count_en 0; count_clr 0; disp_d* 0; lap_active 0; synchronisers 1 (released); debounce counters 0; press pulses 0.
- Debounce, per key:
  - 2-flop synchroniser.
  - Counter increments while the synchronised level differs from the accepted level; it clears on any match.
  - When the counter reaches DB_CYCLES-1, the accepted level flips and the counter clears.
  - A 1-cycle press pulse is emitted in the cycle after the accepted level goes high->low. Release produces no pulse.
  - Holding a key produces exactly one pulse. Glitches shorter than DB_CYCLES produce none.
- States: IDLE=0, RUN=1, PAUSE=2, LAP=3.
- Transitions are evaluated on the pulses in the current cycle. When several pulses are valid in the current state, priority is clr > ps > lap. Pulses that are invalid in the current state are dropped, not queued.
- IDLE:
  - ps -> RUN.
  - clr -> count_clr pulse, stay in IDLE.
  - lap ignored.
- RUN:
  - ps -> PAUSE.
  - lap -> LAP; disp captures cnt_d* in the same edge.
  - cnt_max -> PAUSE; takes precedence over all keys.
  - clr ignored.
- PAUSE:
  - ps -> RUN, unless cnt_max=1, in which case stay in PAUSE.
  - clr -> count_clr pulse, go to IDLE.
  - lap ignored.
- LAP:
  - lap -> RUN; the display returns to live.
  - ps -> PAUSE; the display returns to live.
  - cnt_max -> PAUSE; the display returns to live.
  - clr ignored.
- count_en = 1 in RUN and LAP, else 0. It is registered with the state, so it changes on the edge after the press pulse.
- count_clr is high for exactly one cycle, in the cycle after the accepted clr pulse.
- Display:
  - When lap_active=0, disp_d* <= cnt_d* every cycle (1-cycle lag).
  - When lap_active=1, disp_d* holds the captured value.
  - lap_active = (state == LAP).
- Latency from raw key edge to count_en change: 2 (sync) + DB_CYCLES + 1 (pulse) + 1 (state) cycles.
- A rst assertion at any point overrides all other activity. Any in-flight debounce is discarded, so a key held through reset produces no pulse until it is released and pressed again.

Decomposition:
- Shared package stopwatch_pkg holds the state encodings (IDLE/RUN/PAUSE/LAP as 2-bit constants) and the BCD digit width constant 4.
- One sub-module, key_debounce (params DB_CYCLES, DB_W; ports clk, rst, key_n, press_pulse), instantiated three times.

Test Plan:
- Reset, then all keys released for 50 cycles -> state_out=0, count_en=0, count_clr=0, disp=0000, lap_active=0.
- Run with DB_CYCLES=4. Press key_ps_n low for 10 cycles -> exactly one pulse; count_en rises 2+4+1+1=8 cycles after the edge; state_out=1. A second press -> state_out=2, count_en=0.
- A 3-cycle low glitch on key_ps_n -> no state change. A 10-cycle hold -> exactly one transition, with no repeat while held.
- In RUN with cnt=0123, press lap -> lap_active=1, disp holds 0123 while cnt advances to 0150. Press lap again -> disp tracks cnt with 1-cycle lag.
- In RUN, press clr -> ignored. Press ps, then clr -> count_clr high for exactly 1 cycle, state IDLE. Press clr and ps in the same cycle while in PAUSE -> clr wins, IDLE.
- Drive cnt_max=1 in RUN -> PAUSE on the next edge, count_en=0. A ps press while cnt_max=1 -> stays in PAUSE.
- Assert rst mid-LAP -> all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared state encodings and digit width for the stopwatch control
// Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : Synchronises and debounces one active-low key, emits one press pulse
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int DB_CYCLES = 20,
    parameter int DB_W      = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press_pulse
);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_level;
    logic            r_level_d;
    logic [DB_W-1:0] r_cnt;
    logic [1:0]      r_vld;
    logic            r_armed;
    logic            r_pulse;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_level   <= 1'b1;
            r_level_d <= 1'b1;
            r_cnt     <= '0;
            r_vld     <= '0;
            r_armed   <= 1'b0;
            r_pulse   <= 1'b0;
        end else begin
            r_sync1   <= key_n;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            r_vld     <= {r_vld[0], 1'b1};
            // A key held through reset must be seen released before it may pulse
            r_armed   <= r_armed | (r_vld[1] & r_sync2);
            r_pulse   <= r_armed & r_level_d & ~r_level;
            if (r_sync2 != r_level) begin
                if (r_cnt == DB_W'(DB_CYCLES - 1)) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt   <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign press_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_ctrl
// Description : Key-driven run/pause/lap/clear sequencer for the BCD stopwatch
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DB_CYCLES = 20,
    parameter int DB_W      = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_ps_n,
    input  logic               key_clr_n,
    input  logic               key_lap_n,
    input  logic [DIGIT_W-1:0] cnt_d4,
    input  logic [DIGIT_W-1:0] cnt_d3,
    input  logic [DIGIT_W-1:0] cnt_d2,
    input  logic [DIGIT_W-1:0] cnt_d1,
    input  logic               cnt_max,
    output logic               count_en,
    output logic               count_clr,
    output logic [DIGIT_W-1:0] disp_d4,
    output logic [DIGIT_W-1:0] disp_d3,
    output logic [DIGIT_W-1:0] disp_d2,
    output logic [DIGIT_W-1:0] disp_d1,
    output logic [1:0]         state_out,
    output logic               lap_active
);

    logic   w_ps;
    logic   w_clr;
    logic   w_lap;
    state_t r_state;
    state_t w_state_nxt;
    logic   w_clr_nxt;
    logic   r_count_en;
    logic   r_count_clr;
    logic   r_lap_active;
    logic [4*DIGIT_W-1:0] r_disp;

    key_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_ps (
        .clk(clk), .rst(rst), .key_n(key_ps_n), .press_pulse(w_ps)
    );
    key_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_clr (
        .clk(clk), .rst(rst), .key_n(key_clr_n), .press_pulse(w_clr)
    );
    key_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_lap (
        .clk(clk), .rst(rst), .key_n(key_lap_n), .press_pulse(w_lap)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_clr_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_clr)      w_clr_nxt   = 1'b1;
                else if (w_ps)  w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (cnt_max)    w_state_nxt = ST_PAUSE;
                else if (w_ps)  w_state_nxt = ST_PAUSE;
                else if (w_lap) w_state_nxt = ST_LAP;
            end
            ST_PAUSE: begin
                if (w_clr) begin
                    w_clr_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_ps && !cnt_max) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_LAP: begin
                if (cnt_max)    w_state_nxt = ST_PAUSE;
                else if (w_ps)  w_state_nxt = ST_PAUSE;
                else if (w_lap) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_count_en   <= 1'b0;
            r_count_clr  <= 1'b0;
            r_lap_active <= 1'b0;
            r_disp       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_count_en   <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_LAP);
            r_count_clr  <= w_clr_nxt;
            r_lap_active <= (w_state_nxt == ST_LAP);
            // The capture on entering LAP is simply the last live update
            if (!r_lap_active) begin
                r_disp <= {cnt_d4, cnt_d3, cnt_d2, cnt_d1};
            end
        end
    end

    assign count_en   = r_count_en;
    assign count_clr  = r_count_clr;
    assign lap_active = r_lap_active;
    assign state_out  = r_state;
    assign {disp_d4, disp_d3, disp_d2, disp_d1} = r_disp;

endmodule
`default_nettype wire
